serial_alu_sequencer: RTL and testbench

Bit-serial controller that sequences the 1-bit ALU slice (`adder`) over WIDTH-bit operands, LSB first. It holds operand/result shift registers and the inter-bit carry flop, and drives S/M/Pin to the slice each cycle. It sits between the central unit's control FSM (start/done handshake) and one `adder` instance, giving an N-bit ALU op from a single slice in WIDTH clocks.

---
 rtl/serial_alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// ---------------------------------------------------------------------------
// serial_alu_sequencer
//
// Runs one external 1-bit ALU slice (adder) over WIDTH-bit operands, LSB
// first. The sequencer holds the operand and result shift registers and the
// carry flop between bits. It drives the slice inputs from registers, and the
// slice returns its result bit and carry out combinationally in the same
// cycle. One N-bit operation takes WIDTH clocks.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request an operation (only sampled in IDLE)
//   abort               cancel a running operation (RUN only)
//   op_a, op_b          operands, latched on the accepting edge
//   op_s, op_m          slice function / mode (1 = arithmetic), latched
//   cin                 initial carry, latched; used only when op_m = 1
//   slice_a/b/s/m/pin   drive the slice: current bits, function, mode, carry
//   slice_r, slice_pout from the slice: result bit, carry out of this bit
//   busy                high while in RUN or DONE
//   done                one-cycle pulse; result/cout/zero valid
//   result, cout, zero  outcome of the last completed operation
// ---------------------------------------------------------------------------
module serial_alu_sequencer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             cin,
  output logic             slice_a,
  output logic             slice_b,
  output logic [3:0]       slice_s,
  output logic             slice_m,
  output logic             slice_pin,
  input  logic             slice_r,
  input  logic             slice_pout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic [3:0]       r_s;
  logic             r_m;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;

  // Result register contents once the current slice bit is shifted in; on the
  // last bit this is the finished word.
  logic [WIDTH-1:0] w_r_next;
  assign w_r_next = {slice_r, r_r_sh[WIDTH-1:1]};

  // All slice inputs come straight from registers, so the path through the
  // combinational slice and back into r_r_sh/r_carry is one register stage.
  assign slice_a   = r_a_sh[0];
  assign slice_b   = r_b_sh[0];
  assign slice_s   = r_s;
  assign slice_m   = r_m;
  assign slice_pin = r_carry;

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = r_zero;

  // NOTE: state is updated with non-blocking assignments only, so every read
  // in this block sees the value from before the edge (e.g. r_r_sh in
  // w_r_next), whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_r_sh   <= '0;
      r_s      <= '0;
      r_m      <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      // done is a pulse: cleared every cycle unless the final bit sets it.
      r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= op_a;
            r_b_sh  <= op_b;
            r_s     <= op_s;
            r_m     <= op_m;
            r_carry <= op_m & cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (abort) begin
            // Drop the operation; the previous result/cout/zero stay visible.
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_r_sh  <= w_r_next;
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            // Logic mode never chains carries, so the slice always sees 0.
            r_carry <= r_m & slice_pout;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST_BIT) begin
              r_result <= w_r_next;
              r_cout   <= r_m & slice_pout;
              r_zero   <= (w_r_next == '0);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // start is not sampled here: no back-to-back acceptance.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_serial_alu_sequencer
//
// Drives serial_alu_sequencer (WIDTH = 8) through a table of directed
// operations. It also runs hand-written sequences for reset mid-run, the
// start handshake and abort. A behavioural model of the 1-bit slice closes
// the loop:
//   arithmetic (M=1): full adder, R = a^b^pin, Pout = majority(a,b,pin)
//   logic      (M=0): R = S[{a,b}] (S is a 2-input truth table),
//                     Pout = a|b (non-zero, so the sequencer must mask it)
// ---------------------------------------------------------------------------
module tb_serial_alu_sequencer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_s;
  logic             op_m;
  logic             cin;
  logic             slice_a;
  logic             slice_b;
  logic [3:0]       slice_s;
  logic             slice_m;
  logic             slice_pin;
  logic             slice_r;
  logic             slice_pout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  int n_checks = 0;
  int n_errors = 0;

  serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_s       (op_s),
    .op_m       (op_m),
    .cin        (cin),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_s    (slice_s),
    .slice_m    (slice_m),
    .slice_pin  (slice_pin),
    .slice_r    (slice_r),
    .slice_pout (slice_pout),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .cout       (cout),
    .zero       (zero)
  );

  // Behavioural 1-bit slice.
  always_comb begin
    slice_r    = 1'b0;
    slice_pout = 1'b0;
    if (slice_m) begin
      slice_r    = slice_a ^ slice_b ^ slice_pin;
      slice_pout = (slice_a & slice_b) | (slice_a & slice_pin) | (slice_b & slice_pin);
    end else begin
      slice_r    = slice_s[{slice_a, slice_b}];
      slice_pout = slice_a | slice_b;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cin;
    logic [WIDTH-1:0] exp_r;
    logic             exp_c;
    logic             exp_z;
  } vec_t;

  // Start one operation, track it cycle by cycle, and check the outcome.
  task automatic run_op(input vec_t v, input string name);
    int               edges;
    logic [WIDTH-1:0] a_seq;
    logic             pin_bad;
    logic             busy_bad;
    logic [3:0]       s_seen;
    logic             m_seen;
    @(negedge clk);
    op_a  = v.a;
    op_b  = v.b;
    op_s  = v.s;
    op_m  = v.m;
    cin   = v.cin;
    start = 1'b1;
    @(posedge clk);               // accepting edge ("edge 0")
    #1;
    start = 1'b0;
    // Scramble the inputs: the sequencer must work from its latched copies.
    op_a = ~v.a;
    op_b = ~v.b;
    op_s = ~v.s;
    op_m = ~v.m;
    cin  = ~v.cin;
    s_seen   = slice_s;
    m_seen   = slice_m;
    edges    = 0;
    a_seq    = '0;
    pin_bad  = 1'b0;
    busy_bad = 1'b0;
    while (!done && edges < 20) begin
      if (edges < WIDTH) begin
        a_seq[edges] = slice_a;
        if (!v.m && slice_pin !== 1'b0) pin_bad = 1'b1;
        if (busy !== 1'b1) busy_bad = 1'b1;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    // done is seen after the WIDTH-th edge following the accepting edge.
    check({name, "_latency"}, edges, WIDTH);
    check({name, "_slice_s"}, s_seen, v.s);
    check({name, "_slice_m"}, m_seen, v.m);
    check({name, "_slice_a_seq"}, a_seq, v.a);
    check({name, "_busy_run"}, busy_bad, 1'b0);
    if (!v.m) check({name, "_pin_zero"}, pin_bad, 1'b0);
    check({name, "_result"}, result, v.exp_r);
    check({name, "_cout"}, cout, v.exp_c);
    check({name, "_zero"}, zero, v.exp_z);
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, done, 1'b0);
    check({name, "_idle_busy"}, busy, 1'b0);
    op_s = v.s;
    op_m = v.m;
  endtask

  vec_t vecs [8];

  initial begin
    int   done_cnt;
    int   first_done;
    int   second_done;
    logic seen_done;

    // {a, b, s, m, cin, exp_result, exp_cout, exp_zero}
    vecs[0] = '{8'h5A, 8'h33, 4'b0110, 1'b1, 1'b0, 8'h8D, 1'b0, 1'b0}; // add
    vecs[1] = '{8'hFF, 8'h00, 4'b0110, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1}; // carry wrap
    vecs[2] = '{8'h80, 8'h80, 4'b0110, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1}; // msb carry
    vecs[3] = '{8'h12, 8'h34, 4'b0110, 1'b1, 1'b1, 8'h47, 1'b0, 1'b0}; // add + cin
    vecs[4] = '{8'h0F, 8'h33, 4'b0001, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0}; // NOR
    vecs[5] = '{8'hF0, 8'h0F, 4'b1000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}; // AND
    vecs[6] = '{8'h5A, 8'h33, 4'b0110, 1'b0, 1'b1, 8'h69, 1'b0, 1'b0}; // XOR
    vecs[7] = '{8'h00, 8'h00, 4'b1110, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}; // OR

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;
    op_s  = '0;
    op_m  = 1'b0;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_slice", {slice_a, slice_b, slice_s, slice_m, slice_pin}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // abort is ignored in IDLE: no state change, the table run below works.
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_abort_busy", busy, 1'b0);
    abort = 1'b0;

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-run: carry flop is 1 throughout FF+00+1, so pin must drop.
    @(negedge clk);
    op_a = 8'hFF; op_b = 8'h00; op_s = 4'b0110; op_m = 1'b1; cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_pin", slice_pin, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 8'h00);
    check("midrst_cout_zero", {cout, zero}, 2'b00);
    check("midrst_slice", {slice_a, slice_b, slice_s, slice_m, slice_pin}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[0], "post_rst");

    // Handshake: start held high. Accept at edge 0, done after edge 8,
    // IDLE after edge 9, second accept at edge 10, second done after edge 18.
    @(negedge clk);
    op_a = 8'h5A; op_b = 8'h33; op_s = 4'b0110; op_m = 1'b1; cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    op_a = 8'h01;                  // next op's operands, changed mid-run
    op_b = 8'h01;
    done_cnt    = 0;
    first_done  = -1;
    second_done = -1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_done = e;
          check("hs_result1", result, 8'h8D);
        end else if (done_cnt == 2) begin
          second_done = e;
          check("hs_result2", result, 8'h02);
        end
      end
      if (e == 9) check("hs_idle_gap", busy, 1'b0);
      if (e == 10) begin
        check("hs_reaccept", busy, 1'b1);
        start = 1'b0;
      end
    end
    check("hs_done_count", done_cnt, 2);
    check("hs_done1_edge", first_done, 8);
    check("hs_done2_edge", second_done, 18);

    // Abort in RUN cycle 4; the previous 0x8D result must survive.
    run_op(vecs[0], "pre_abort");
    @(negedge clk);
    op_a = 8'hFF; op_b = 8'h00; op_s = 4'b0110; op_m = 1'b1; cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) seen_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", seen_done, 1'b0);
    check("abort_result", result, 8'h8D);
    check("abort_cout_zero", {cout, zero}, 2'b00);

    // Abort coinciding with the final RUN edge: abort wins.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (WIDTH - 1) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_last_done", done, 1'b0);
    check("abort_last_busy", busy, 1'b0);
    check("abort_last_result", {cout, zero, result}, {2'b00, 8'h8D});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
